// File: rtl/tmr_pkg.sv
// Shared encodings for the dynamic-TMR datapath: mode values, enable patterns
// and the error-rate field used between the vote monitor and the control unit.
package tmr_pkg;

    localparam logic [1:0] MODE_SIMPLEX = 2'd0;
    localparam logic [1:0] MODE_WARMUP  = 2'd1;
    localparam logic [1:0] MODE_TMR     = 2'd2;

    localparam int         ERR_W   = 4;
    localparam logic [3:0] ERR_MAX = 4'd15;

    localparam logic [2:0] EN_TMR     = 3'b111;
    localparam logic [2:0] EN_SIMPLEX = 3'b001;

    typedef enum logic [1:0] {
        ST_SIMPLEX = MODE_SIMPLEX,
        ST_WARMUP  = MODE_WARMUP,
        ST_TMR     = MODE_TMR
    } tmr_state_e;

    function automatic logic is_tmr_request(input logic [2:0] en);
        return en == EN_TMR;
    endfunction

endpackage

// File: rtl/tmr_maj3.sv
// Bitwise 2-of-3 majority voter with per-module disagreement flags.
// Purely combinational so it can sit on any voted path.
module tmr_maj3 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] maj,
    output logic [2:0]       fault_map
);

    assign maj = (d0 & d1) | (d1 & d2) | (d0 & d2);

    // A module is suspect when any of its bits was outvoted.
    assign fault_map = {|(d2 ^ maj), |(d1 ^ maj), |(d0 ^ maj)};

endmodule

// File: rtl/tmr_vote_monitor.sv
// Datapath end of the dynamic-TMR loop: votes or passes through the module
// outputs and reports a windowed, saturating disagreement rate back to control.
module tmr_vote_monitor
    import tmr_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 256,
    parameter int WARMUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic             out_valid,
    output logic [WIDTH-1:0] dout,
    output logic             mismatch,
    output logic [2:0]       fault_map,
    output logic [3:0]       err_rate,
    output logic [1:0]       mode
);

    localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int WU_W  = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [WU_W-1:0]  WU_LOAD  = WU_W'(WARMUP - 1);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] x);
        return (x == ERR_MAX) ? x : x + 1'b1;
    endfunction

    function automatic logic [ERR_W-1:0] dec_floor(input logic [ERR_W-1:0] x);
        return (x == '0) ? x : x - 1'b1;
    endfunction

    tmr_state_e       state_p1;
    logic [WU_W-1:0]  wu_cnt_p1;
    logic [WIN_W-1:0] win_cnt_p1;
    logic [ERR_W-1:0] ev_cnt_p1;
    logic [ERR_W-1:0] err_rate_p1;
    logic             vld_p1;
    logic [WIDTH-1:0] dout_p1;
    logic             mismatch_p1;
    logic [2:0]       fault_map_p1;

    logic [WIDTH-1:0] maj_p0;
    logic [2:0]       fm_p0;
    logic             in_tmr_p0;
    logic             en_tmr_p0;
    logic             beat_err_p0;
    logic             win_term_p0;
    logic [ERR_W-1:0] ev_next_p0;

    tmr_maj3 #(.WIDTH(WIDTH)) u_maj3 (
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .maj       (maj_p0),
        .fault_map (fm_p0)
    );

    // ---- stage p0: vote, classify the beat, detect window close ----
    assign in_tmr_p0   = (state_p1 == ST_TMR);
    assign en_tmr_p0   = is_tmr_request(en);
    assign beat_err_p0 = in_tmr_p0 && in_valid && (|fm_p0);
    assign win_term_p0 = (win_cnt_p1 == WIN_LAST);
    assign ev_next_p0  = beat_err_p0 ? sat_inc(ev_cnt_p1) : ev_cnt_p1;

    // ---- stage p1: registered outputs, counters and mode sequencing ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1     <= ST_SIMPLEX;
            wu_cnt_p1    <= '0;
            win_cnt_p1   <= '0;
            ev_cnt_p1    <= '0;
            err_rate_p1  <= '0;
            vld_p1       <= 1'b0;
            dout_p1      <= '0;
            mismatch_p1  <= 1'b0;
            fault_map_p1 <= '0;
        end else begin
            vld_p1 <= in_valid;

            if (in_valid) begin
                if (in_tmr_p0) begin
                    dout_p1      <= maj_p0;
                    fault_map_p1 <= fm_p0;
                    mismatch_p1  <= |fm_p0;
                end else begin
                    dout_p1      <= d0;
                    fault_map_p1 <= '0;
                    mismatch_p1  <= 1'b0;
                end
            end

            win_cnt_p1 <= win_term_p0 ? '0 : win_cnt_p1 + 1'b1;

            // Unprotected windows decay the rate so control does not flap.
            if (win_term_p0) begin
                err_rate_p1 <= in_tmr_p0 ? ev_next_p0 : dec_floor(err_rate_p1);
                ev_cnt_p1   <= '0;
            end else if (in_tmr_p0 && !en_tmr_p0) begin
                ev_cnt_p1   <= '0;
            end else begin
                ev_cnt_p1   <= ev_next_p0;
            end

            case (state_p1)
                ST_SIMPLEX: begin
                    if (en_tmr_p0) begin
                        state_p1  <= ST_WARMUP;
                        wu_cnt_p1 <= WU_LOAD;
                    end
                end
                ST_WARMUP: begin
                    if (!en_tmr_p0) begin
                        state_p1 <= ST_SIMPLEX;
                    end else if (wu_cnt_p1 == '0) begin
                        state_p1 <= ST_TMR;
                    end else begin
                        wu_cnt_p1 <= wu_cnt_p1 - 1'b1;
                    end
                end
                ST_TMR: begin
                    if (!en_tmr_p0) begin
                        state_p1 <= ST_SIMPLEX;
                    end
                end
                default: state_p1 <= ST_SIMPLEX;
            endcase
        end
    end

    assign out_valid = vld_p1;
    assign dout      = dout_p1;
    assign mismatch  = mismatch_p1;
    assign fault_map = fault_map_p1;
    assign err_rate  = err_rate_p1;
    assign mode      = state_p1;

endmodule
